// File: rtl/ctrl_bubble_stage.sv
// ID/EX control-field register: passes packed WB/MEM/EX control through one
// register stage, or substitutes zeroed bubbles for hazards, counted bubble runs and flushes.
module ctrl_bubble_stage #(
  parameter int unsigned WB_W  = 2,
  parameter int unsigned MEM_W = 2,
  parameter int unsigned EX_W  = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [WB_W+MEM_W+EX_W-1:0]  ctrl_i,
  input  logic                        valid_i,
  input  logic                        hd_i,
  input  logic                        bubble_req_i,
  input  logic [CNT_W-1:0]            bubble_n_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  output logic [WB_W-1:0]             wb_o,
  output logic [MEM_W-1:0]            mem_o,
  output logic [EX_W-1:0]             ex_o,
  output logic                        valid_o,
  output logic                        bubble_o,
  output logic                        busy_o,
  output logic [CNT_W-1:0]            bubble_cnt_o
);

  localparam int unsigned CTRL_W = WB_W + MEM_W + EX_W;

  typedef enum logic {
    RUN,
    BUBBLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q;
  logic             load_bubble;
  logic             flush_eff;
  logic             req_eff;

  logic [WB_W-1:0]  wb_q;
  logic [MEM_W-1:0] mem_q;
  logic [EX_W-1:0]  ex_q;
  logic             valid_q;
  logic             bubble_q;

  // A flush seen during a stall is remembered so the first advancing edge honours it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      wb_q         <= '0;
      mem_q        <= '0;
      ex_q         <= '0;
      valid_q      <= 1'b0;
      bubble_q     <= 1'b0;
    end else if (stall_i) begin
      flush_pend_q <= flush_pend_q | flush_i;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= 1'b0;
      if (load_bubble) begin
        wb_q     <= '0;
        mem_q    <= '0;
        ex_q     <= '0;
        valid_q  <= 1'b0;
        bubble_q <= 1'b1;
      end else begin
        wb_q     <= ctrl_i[CTRL_W-1 -: WB_W];
        mem_q    <= ctrl_i[EX_W+MEM_W-1 -: MEM_W];
        ex_q     <= ctrl_i[EX_W-1:0];
        valid_q  <= valid_i;
        bubble_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_bubble = 1'b0;
    flush_eff   = flush_i | flush_pend_q;
    req_eff     = bubble_req_i && (bubble_n_i != '0);
    if (flush_eff) begin
      load_bubble = 1'b1;
      cnt_d       = '0;
      state_d     = RUN;
    end else if (state_q == BUBBLE) begin
      load_bubble = 1'b1;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (cnt_q <= CNT_W'(1)) begin
        state_d = RUN;
      end
    end else if (req_eff) begin
      load_bubble = 1'b1;
      cnt_d       = bubble_n_i - CNT_W'(1);
      state_d     = (bubble_n_i > CNT_W'(1)) ? BUBBLE : RUN;
    end else if (hd_i) begin
      load_bubble = 1'b1;
    end
  end

  always_comb begin
    wb_o         = wb_q;
    mem_o        = mem_q;
    ex_o         = ex_q;
    valid_o      = valid_q;
    bubble_o     = bubble_q;
    busy_o       = (state_q == BUBBLE);
    bubble_cnt_o = cnt_q;
  end

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Directed bench for ctrl_bubble_stage: hand-computed vectors for pass, hazard,
// counted bubbles, stall hold, flush handling and reset priority.
module tb_ctrl_bubble_stage;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] ctrl_i;
  logic       valid_i;
  logic       hd_i;
  logic       bubble_req_i;
  logic [2:0] bubble_n_i;
  logic       stall_i;
  logic       flush_i;
  logic [1:0] wb_o;
  logic [1:0] mem_o;
  logic [3:0] ex_o;
  logic       valid_o;
  logic       bubble_o;
  logic       busy_o;
  logic [2:0] bubble_cnt_o;

  int checks   = 0;
  int failures = 0;

  ctrl_bubble_stage #(
    .WB_W (2),
    .MEM_W(2),
    .EX_W (4),
    .CNT_W(3)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ctrl_i      (ctrl_i),
    .valid_i     (valid_i),
    .hd_i        (hd_i),
    .bubble_req_i(bubble_req_i),
    .bubble_n_i  (bubble_n_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .wb_o        (wb_o),
    .mem_o       (mem_o),
    .ex_o        (ex_o),
    .valid_o     (valid_o),
    .bubble_o    (bubble_o),
    .busy_o      (busy_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [1:0] wb, input logic [1:0] mem,
                            input logic [3:0] ex, input logic v, input logic b,
                            input logic busy, input logic [2:0] cnt);
    check({tag, ".wb"},     32'(wb_o),         32'(wb));
    check({tag, ".mem"},    32'(mem_o),        32'(mem));
    check({tag, ".ex"},     32'(ex_o),         32'(ex));
    check({tag, ".valid"},  32'(valid_o),      32'(v));
    check({tag, ".bubble"}, 32'(bubble_o),     32'(b));
    check({tag, ".busy"},   32'(busy_o),       32'(busy));
    check({tag, ".cnt"},    32'(bubble_cnt_o), 32'(cnt));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_bubble(input string tag, input logic busy, input logic [2:0] cnt);
    expect_all(tag, 2'b00, 2'b00, 4'h0, 1'b0, 1'b1, busy, cnt);
  endtask

  initial begin
    rst_i = 1'b1; ctrl_i = 8'hFF; valid_i = 1'b1; hd_i = 1'b0;
    bubble_req_i = 1'b0; bubble_n_i = 3'd0; stall_i = 1'b0; flush_i = 1'b0;

    step(); step();
    expect_all("reset", 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_i = 1'b0;
    step();
    expect_all("post_reset", 2'b11, 2'b11, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0);

    // load-use hazard
    ctrl_i = 8'hA5; hd_i = 1'b1;
    step();
    expect_bubble("hd_bubble", 1'b0, 3'd0);
    hd_i = 1'b0;
    step();
    expect_all("hd_pass", 2'b10, 2'b10, 4'h5, 1'b1, 1'b0, 1'b0, 3'd0);

    // multi-bubble with simultaneous hd: exactly 3
    ctrl_i = 8'h96; bubble_req_i = 1'b1; bubble_n_i = 3'd3; hd_i = 1'b1;
    step();
    expect_bubble("mb1", 1'b1, 3'd2);
    bubble_req_i = 1'b0; hd_i = 1'b0;
    step();
    expect_bubble("mb2", 1'b1, 3'd1);
    step();
    expect_bubble("mb3", 1'b0, 3'd0);
    step();
    expect_all("mb_pass", 2'b10, 2'b01, 4'h6, 1'b1, 1'b0, 1'b0, 3'd0);

    // stall during bubble 2 of 3
    ctrl_i = 8'h4B; bubble_req_i = 1'b1; bubble_n_i = 3'd3;
    step();
    expect_bubble("st_b1", 1'b1, 3'd2);
    bubble_req_i = 1'b0;
    step();
    expect_bubble("st_b2", 1'b1, 3'd1);
    stall_i = 1'b1; ctrl_i = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_bubble("st_hold", 1'b1, 3'd1);
    end
    stall_i = 1'b0;
    step();
    expect_bubble("st_b3", 1'b0, 3'd0);
    step();
    expect_all("st_pass", 2'b11, 2'b00, 4'h3, 1'b1, 1'b0, 1'b0, 3'd0);

    // flush pulsed during a stall
    stall_i = 1'b1; ctrl_i = 8'h3C;
    step();
    expect_all("fs_hold1", 2'b11, 2'b00, 4'h3, 1'b1, 1'b0, 1'b0, 3'd0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    expect_all("fs_hold2", 2'b11, 2'b00, 4'h3, 1'b1, 1'b0, 1'b0, 3'd0);
    step();
    expect_all("fs_hold3", 2'b11, 2'b00, 4'h3, 1'b1, 1'b0, 1'b0, 3'd0);
    stall_i = 1'b0;
    step();
    expect_bubble("fs_bubble", 1'b0, 3'd0);
    step();
    expect_all("fs_pass", 2'b00, 2'b11, 4'hC, 1'b1, 1'b0, 1'b0, 3'd0);

    // flush mid-BUBBLE, N=5 -> 3 bubbles
    ctrl_i = 8'hE7; bubble_req_i = 1'b1; bubble_n_i = 3'd5;
    step();
    expect_bubble("fb_b1", 1'b1, 3'd4);
    bubble_req_i = 1'b0;
    step();
    expect_bubble("fb_b2", 1'b1, 3'd3);
    flush_i = 1'b1;
    step();
    expect_bubble("fb_flush", 1'b0, 3'd0);
    flush_i = 1'b0;
    step();
    expect_all("fb_pass", 2'b11, 2'b10, 4'h7, 1'b1, 1'b0, 1'b0, 3'd0);

    // N=0 is ignored; falls through to pass, then to hd
    ctrl_i = 8'h81; bubble_req_i = 1'b1; bubble_n_i = 3'd0;
    step();
    expect_all("n0_pass", 2'b10, 2'b00, 4'h1, 1'b1, 1'b0, 1'b0, 3'd0);
    hd_i = 1'b1;
    step();
    expect_bubble("n0_hd", 1'b0, 3'd0);
    hd_i = 1'b0; bubble_req_i = 1'b0;

    // N=1: single bubble, stays in RUN
    ctrl_i = 8'h42; bubble_req_i = 1'b1; bubble_n_i = 3'd1;
    step();
    expect_bubble("n1_b", 1'b0, 3'd0);
    bubble_req_i = 1'b0; valid_i = 1'b0;
    step();
    expect_all("n1_pass_inv", 2'b01, 2'b00, 4'h2, 1'b0, 1'b0, 1'b0, 3'd0);
    valid_i = 1'b1;

    // N=7 maximum run
    ctrl_i = 8'h18; bubble_req_i = 1'b1; bubble_n_i = 3'd7;
    step();
    expect_bubble("n7_b1", 1'b1, 3'd6);
    bubble_req_i = 1'b0;
    for (int k = 5; k >= 0; k--) begin
      step();
      expect_bubble("n7_run", (k != 0), 3'(k));
    end
    step();
    expect_all("n7_pass", 2'b00, 2'b01, 4'h8, 1'b1, 1'b0, 1'b0, 3'd0);

    // reset mid-BUBBLE discards remaining bubbles
    bubble_req_i = 1'b1; bubble_n_i = 3'd5;
    step();
    expect_bubble("rb_b1", 1'b1, 3'd4);
    bubble_req_i = 1'b0; rst_i = 1'b1;
    step();
    expect_all("rb_reset", 2'b00, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_i = 1'b0; ctrl_i = 8'h69;
    step();
    expect_all("rb_pass", 2'b01, 2'b10, 4'h9, 1'b1, 1'b0, 1'b0, 3'd0);

    // reset clears a pending flush
    stall_i = 1'b1; flush_i = 1'b1;
    step();
    flush_i = 1'b0; rst_i = 1'b1;
    step();
    rst_i = 1'b0; stall_i = 1'b0; ctrl_i = 8'hD2;
    step();
    expect_all("rf_pass", 2'b11, 2'b01, 4'h2, 1'b1, 1'b0, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
